// File: rtl/wavegen_pkg.sv
// wavegen_pkg: waveform modes and reset defaults shared by the wavegen blocks
package wavegen_pkg;
  typedef enum logic [1:0] {SAW_UP = 2'd0, SAW_DN = 2'd1, TRI = 2'd2, SQUARE = 2'd3} mode_e;
  localparam int DEF_STEP = 1;
  function automatic int def_duty(input int w);
    return 1 << (w - 1);
  endfunction
endpackage

// File: rtl/wavegen_prescaler.sv
// wavegen_prescaler: enable-gated tick pulse every div+1 clks
module wavegen_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);
  logic [PRESC_W-1:0] r_cnt;
  logic               r_tick;
  // terminal count uses >= so lowering div below the count fires on the next clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= enable && r_cnt >= div;
      if (enable) r_cnt <= r_cnt >= div ? '0 : r_cnt + 1'b1;
    end
  assign tick = r_tick & enable;
endmodule

// File: rtl/wavegen_dac.sv
// wavegen_dac: phase-accumulator waveform generator driving an R-2R parallel DAC
module wavegen_dac
  import wavegen_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PRESC_W-1:0] presc_div,
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   step,
  input  logic [WIDTH-1:0]   duty,
  output logic [WIDTH-1:0]   dac,
  output logic               tick,
  output logic               wrap
);
  logic [WIDTH-1:0] r_phase, r_step_sh, r_duty_sh, r_dac, w_f, w_map;
  logic [WIDTH:0]   w_sum;
  mode_e            r_mode_sh;
  logic             r_wrap, w_carry;
  wavegen_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .div    (presc_div),
    .tick   (tick)
  );
  assign w_sum   = {1'b0, r_phase} + {1'b0, r_step_sh};
  assign w_carry = tick & w_sum[WIDTH];
  assign w_f     = {r_phase[WIDTH-2:0], 1'b0};
  assign dac     = r_dac;
  assign wrap    = r_wrap & enable;
  // phase-to-code mapping for the active (shadowed) mode
  always_comb
    w_map = r_mode_sh == SAW_UP ? r_phase :
            r_mode_sh == SAW_DN ? ~r_phase :
            r_mode_sh == TRI    ? (r_phase[WIDTH-1] ? ~w_f : w_f) :
            (r_phase < r_duty_sh ? {WIDTH{1'b1}} : '0);
  // accumulator, period-boundary config capture and registered DAC code
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_phase   <= '0;
      r_dac     <= '0;
      r_wrap    <= 1'b0;
      r_mode_sh <= SAW_UP;
      r_step_sh <= WIDTH'(DEF_STEP);
      r_duty_sh <= WIDTH'(def_duty(WIDTH));
    end else begin
      r_wrap <= w_carry;
      if (tick) r_phase <= w_sum[WIDTH-1:0];
      if (enable) r_dac <= w_map;
      if (w_carry || !enable) begin
        r_mode_sh <= mode;
        r_step_sh <= step;
        r_duty_sh <= duty;
      end
    end
endmodule
